// File: rtl/riscv_lsu_axil_ctrl.sv
// ============================================================================
// Module   : riscv_lsu_axil_ctrl
// Purpose  : RISC-V load/store sequencer onto a 64-bit AXI-Lite master port.
//            Optional macro RISCV_LSU_MISALIGN_TRAP_EN traps misaligned access.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_lsu_axil_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [2:0]            i_req_width,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    output logic                  o_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                  o_rsp_err,
    output logic                  o_awvalid,
    input  logic                  i_awready,
    output logic [ADDR_WIDTH-1:0] o_awaddr,
    output logic                  o_wvalid,
    input  logic                  i_wready,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic [STRB_WIDTH-1:0] o_wstrb,
    input  logic                  i_bvalid,
    output logic                  o_bready,
    input  logic [1:0]            i_bresp,
    output logic                  o_arvalid,
    input  logic                  i_arready,
    output logic [ADDR_WIDTH-1:0] o_araddr,
    input  logic                  i_rvalid,
    output logic                  o_rready,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    input  logic [1:0]            i_rresp
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR      = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_ADDR = 3'd3,
        S_RD_DATA = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [2:0]              addr_lo_q;
    logic [2:0]              width_q;
    logic [ADDR_WIDTH-1:0]   baddr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_WIDTH-1:0]   wstrb_q;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic                    trap_q, trap_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    latch_req;

    logic [STRB_WIDTH-1:0]   lane_strb;
    logic [DATA_WIDTH-1:0]   lane_data;
    logic                    misalign;
    logic [DATA_WIDTH-1:0]   rd_shift;
    logic [DATA_WIDTH-1:0]   rd_ext;

    // Store lane placement, computed from the request so it can be registered at accept
    always_comb begin
        lane_strb = '1;
        lane_data = i_req_wdata;
        case (i_req_width[1:0])
            2'd0: begin
                lane_strb = 8'h01 << i_req_addr[2:0];
                lane_data = {8{i_req_wdata[7:0]}};
            end
            2'd1: begin
                lane_strb = 8'h03 << {i_req_addr[2:1], 1'b0};
                lane_data = {4{i_req_wdata[15:0]}};
            end
            2'd2: begin
                lane_strb = 8'h0F << {i_req_addr[2], 2'b00};
                lane_data = {2{i_req_wdata[31:0]}};
            end
            default: begin
                lane_strb = '1;
                lane_data = i_req_wdata;
            end
        endcase
    end

`ifdef RISCV_LSU_MISALIGN_TRAP_EN
    always_comb begin
        misalign = 1'b0;
        case (i_req_width[1:0])
            2'd1:    misalign = i_req_addr[0];
            2'd2:    misalign = |i_req_addr[1:0];
            2'd3:    misalign = |i_req_addr[2:0];
            default: misalign = 1'b0;
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    // Load lane extraction: low address bits below natural alignment are dropped
    always_comb begin
        rd_shift = i_rdata;
        rd_ext   = i_rdata;
        case (width_q[1:0])
            2'd0: begin
                rd_shift = i_rdata >> {addr_lo_q, 3'b000};
                rd_ext   = width_q[2] ? {56'd0, rd_shift[7:0]}
                                      : {{56{rd_shift[7]}}, rd_shift[7:0]};
            end
            2'd1: begin
                rd_shift = i_rdata >> {addr_lo_q[2:1], 4'b0000};
                rd_ext   = width_q[2] ? {48'd0, rd_shift[15:0]}
                                      : {{48{rd_shift[15]}}, rd_shift[15:0]};
            end
            2'd2: begin
                rd_shift = i_rdata >> {addr_lo_q[2], 5'b00000};
                rd_ext   = width_q[2] ? {32'd0, rd_shift[31:0]}
                                      : {{32{rd_shift[31]}}, rd_shift[31:0]};
            end
            default: begin
                rd_shift = i_rdata;
                rd_ext   = i_rdata;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        trap_d      = trap_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        latch_req   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_req_valid) begin
                    latch_req = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (misalign) begin
                        trap_d  = 1'b1;
                        state_d = S_DONE;
                    end else if (i_req_we) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD_ADDR;
                    end
                end
            end
            S_WR: begin
                aw_done_d = aw_done_q | i_awready;
                w_done_d  = w_done_q | i_wready;
                if (aw_done_d && w_done_d) begin
                    state_d = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (i_bvalid) begin
                    rsp_err_d   = |i_bresp;
                    rsp_rdata_d = '0;
                    state_d     = S_DONE;
                end
            end
            S_RD_ADDR: begin
                if (i_arready) begin
                    state_d = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (i_rvalid) begin
                    rsp_err_d   = |i_rresp;
                    rsp_rdata_d = (|i_rresp) ? '0 : rd_ext;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                // A trapped access spends one silent cycle here before responding
                if (trap_q) begin
                    trap_d      = 1'b0;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            addr_lo_q   <= '0;
            width_q     <= '0;
            baddr_q     <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            trap_q      <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            trap_q      <= trap_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            if (latch_req) begin
                addr_lo_q <= i_req_addr[2:0];
                width_q   <= i_req_width;
                baddr_q   <= {i_req_addr[ADDR_WIDTH-1:3], 3'b000};
                wdata_q   <= lane_data;
                wstrb_q   <= lane_strb;
            end
        end
    end

    assign o_req_ready = (state_q == S_IDLE);
    assign o_awvalid   = (state_q == S_WR) && !aw_done_q;
    assign o_wvalid    = (state_q == S_WR) && !w_done_q;
    assign o_bready    = (state_q == S_WR_RESP);
    assign o_arvalid   = (state_q == S_RD_ADDR);
    assign o_rready    = (state_q == S_RD_DATA);
    assign o_rsp_valid = (state_q == S_DONE) && !trap_q;
    assign o_rsp_rdata = rsp_rdata_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_awaddr    = baddr_q;
    assign o_araddr    = baddr_q;
    assign o_wdata     = wdata_q;
    assign o_wstrb     = wstrb_q;

endmodule

`default_nettype wire

// File: tb/tb_riscv_lsu_axil_ctrl.sv
// ============================================================================
// Module   : tb_riscv_lsu_axil_ctrl
// Purpose  : Scoreboard bench for riscv_lsu_axil_ctrl with an AXI-Lite slave model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_riscv_lsu_axil_ctrl;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        i_req_we = 1'b0;
    logic [31:0] i_req_addr = '0;
    logic [2:0]  i_req_width = '0;
    logic [63:0] i_req_wdata = '0;
    logic        i_awready = 1'b0, i_wready = 1'b0, i_bvalid = 1'b0;
    logic        i_arready = 1'b0, i_rvalid = 1'b0;
    logic [1:0]  i_bresp = '0, i_rresp = '0;
    logic [63:0] i_rdata = '0;
    wire         o_req_ready, o_rsp_valid, o_rsp_err;
    wire  [63:0] o_rsp_rdata, o_wdata;
    wire         o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready;
    wire  [31:0] o_awaddr, o_araddr;
    wire  [7:0]  o_wstrb;

    riscv_lsu_axil_ctrl dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
        .i_req_addr(i_req_addr), .i_req_width(i_req_width), .i_req_wdata(i_req_wdata),
        .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
        .o_awvalid(o_awvalid), .i_awready(i_awready), .o_awaddr(o_awaddr),
        .o_wvalid(o_wvalid), .i_wready(i_wready), .o_wdata(o_wdata), .o_wstrb(o_wstrb),
        .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bresp(i_bresp),
        .o_arvalid(o_arvalid), .i_arready(i_arready), .o_araddr(o_araddr),
        .i_rvalid(i_rvalid), .o_rready(o_rready), .i_rdata(i_rdata), .i_rresp(i_rresp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [2:0]  width;
        logic [63:0] wdata;
        logic [63:0] bus;
        logic [1:0]  resp;
        int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
    } txn_t;

    typedef struct {
        logic [63:0] rdata;
        bit          err;
        int          lat;
    } exp_t;

    txn_t slq[$];
    exp_t scq[$];
    int   accq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic int nbytes(input txn_t t);
        return 1 << t.width[1:0];
    endfunction

    function automatic int lane_off(input txn_t t);
        return int'(t.addr[2:0]) & ~(nbytes(t) - 1);
    endfunction

    function automatic bit trapped(input txn_t t);
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
        return (int'(t.addr[2:0]) % nbytes(t)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [63:0] byte_mask(input int n);
        return (n == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * n)) - 64'd1);
    endfunction

    function automatic exp_t model(input txn_t t);
        exp_t        e;
        int          n;
        logic [63:0] m, v;
        n = nbytes(t);
        m = byte_mask(n);
        e.lat = -1;
        if (trapped(t)) begin
            e.rdata = '0;
            e.err   = 1'b1;
        end else if (t.resp != 2'b00) begin
            e.rdata = '0;
            e.err   = 1'b1;
        end else if (t.we) begin
            e.rdata = '0;
            e.err   = 1'b0;
        end else begin
            v = (t.bus >> (8 * lane_off(t))) & m;
            if (n < 8 && !t.width[2] && v[8 * n - 1]) v = v | ~m;
            e.rdata = v;
            e.err   = 1'b0;
        end
        return e;
    endfunction

    function automatic txn_t mk(input bit we, input logic [31:0] addr, input logic [2:0] width,
                                input logic [63:0] wdata, input logic [63:0] bus,
                                input logic [1:0] resp);
        txn_t t;
        t.we = we; t.addr = addr; t.width = width; t.wdata = wdata; t.bus = bus; t.resp = resp;
        t.aw_dly = 0; t.w_dly = 0; t.b_dly = 0; t.ar_dly = 0; t.r_dly = 0;
        return t;
    endfunction

    // AXI-Lite slave model: checks bus-side beats against the current transaction
    initial begin
        int   awc, wc, bc, arc, rc;
        bit   awg, wg, arg, aw_pend, w_pend, ar_pend;
        txn_t cur;
        logic [7:0]  xs;
        logic [63:0] lm;
        awc = 0; wc = 0; bc = 0; arc = 0; rc = 0;
        awg = 0; wg = 0; arg = 0; aw_pend = 0; w_pend = 0; ar_pend = 0;
        forever begin
            @(negedge clk);
            if (i_rst) begin
                slq.delete();
                awc = 0; wc = 0; bc = 0; arc = 0; rc = 0;
                awg = 0; wg = 0; arg = 0; aw_pend = 0; w_pend = 0; ar_pend = 0;
            end else if (slq.size() == 0) begin
                if (o_awvalid || o_wvalid || o_arvalid) chk("unexpected_bus_valid", 1, 0);
            end else begin
                cur = slq[0];
                if (aw_pend) chk("awvalid_held", o_awvalid, 1);
                if (w_pend)  chk("wvalid_held", o_wvalid, 1);
                if (ar_pend) chk("arvalid_held", o_arvalid, 1);
                aw_pend = o_awvalid && !i_awready;
                w_pend  = o_wvalid && !i_wready;
                ar_pend = o_arvalid && !i_arready;
                if (o_awvalid) begin
                    if (awg || !cur.we) chk("aw_spurious", 1, 0);
                    if (i_awready) begin
                        chk("awaddr", o_awaddr, {cur.addr[31:3], 3'b000});
                        awg = 1;
                    end else awc++;
                end
                if (o_wvalid) begin
                    if (wg || !cur.we) chk("w_spurious", 1, 0);
                    if (i_wready) begin
                        xs = 8'(((1 << nbytes(cur)) - 1) << lane_off(cur));
                        lm = byte_mask(nbytes(cur)) << (8 * lane_off(cur));
                        chk("wstrb", o_wstrb, xs);
                        chk("wdata_lane", o_wdata & lm,
                            (cur.wdata & byte_mask(nbytes(cur))) << (8 * lane_off(cur)));
                        wg = 1;
                    end else wc++;
                end
                if (o_arvalid) begin
                    if (arg || cur.we) chk("ar_spurious", 1, 0);
                    if (i_arready) begin
                        chk("araddr", o_araddr, {cur.addr[31:3], 3'b000});
                        arg = 1;
                    end else arc++;
                end
                if (i_bvalid && o_bready) begin
                    void'(slq.pop_front());
                    awc = 0; wc = 0; bc = 0; awg = 0; wg = 0;
                end else if (awg && wg) bc++;
                if (i_rvalid && o_rready) begin
                    void'(slq.pop_front());
                    arc = 0; rc = 0; arg = 0;
                end else if (arg) rc++;
            end
            @(posedge clk); #1;
            if (slq.size() != 0) begin
                cur = slq[0];
                i_awready = (awc >= cur.aw_dly);
                i_wready  = (wc >= cur.w_dly);
                i_arready = (arc >= cur.ar_dly);
                i_bvalid  = awg && wg && (bc >= cur.b_dly);
                i_bresp   = cur.resp;
                i_rvalid  = arg && (rc >= cur.r_dly);
                i_rresp   = cur.resp;
                i_rdata   = cur.bus;
            end else begin
                i_awready = 0; i_wready = 0; i_arready = 0; i_bvalid = 0; i_rvalid = 0;
            end
        end
    end

    // Response monitor: pops the scoreboard whenever a completion pulse appears
    initial begin
        exp_t e;
        int   acc;
        bit   prev_rsp;
        prev_rsp = 0;
        forever begin
            @(negedge clk);
            if (i_rst) begin
                accq.delete();
                prev_rsp = 0;
            end else begin
                if (prev_rsp) chk("req_ready_after_rsp", o_req_ready, 1);
                if (i_req_valid && o_req_ready) accq.push_back(cyc);
                if (o_rsp_valid) begin
                    if (scq.size() == 0) chk("unexpected_rsp", 1, 0);
                    else begin
                        e = scq.pop_front();
                        acc = (accq.size() != 0) ? accq.pop_front() : -1000;
                        chk("rsp_rdata", o_rsp_rdata, e.rdata);
                        chk("rsp_err", o_rsp_err, e.err);
                        if (e.lat >= 0) chk("rsp_latency", cyc - acc, e.lat);
                    end
                end
                prev_rsp = o_rsp_valid;
            end
        end
    end

    task automatic issue(input txn_t t, input bit chk_lat);
        exp_t e;
        bit   ok;
        e = model(t);
        if (chk_lat) e.lat = trapped(t) ? 2 : 3;
        scq.push_back(e);
        if (!trapped(t)) slq.push_back(t);
        i_req_valid = 1; i_req_we = t.we; i_req_addr = t.addr;
        i_req_width = t.width; i_req_wdata = t.wdata;
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (o_req_ready) begin ok = 1; break; end
        end
        if (!ok) chk("accept_timeout", 1, 0);
        @(posedge clk); #1;
        i_req_valid = 0;
        ok = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (scq.size() == 0) begin ok = 1; break; end
        end
        if (!ok) begin
            chk("response_timeout", 1, 0);
            scq.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        txn_t t;
        bit   ok;
        int   r;
        repeat (3) @(posedge clk);
        #1 i_rst = 0;
        @(negedge clk);
        chk("rst_req_ready", o_req_ready, 1);
        chk("rst_valids", {o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready, o_rsp_valid}, 0);
        chk("rst_rdata_err", {o_rsp_rdata, o_rsp_err}, 0);
        chk("rst_addr_strb", {o_awaddr, o_araddr, o_wstrb}, 0);
        chk("rst_wdata", o_wdata, 0);
        @(posedge clk); #1;

        issue(mk(1, 32'h1005, 3'd0, 64'hAB, 64'h0, 2'b00), 1);
        issue(mk(0, 32'h2006, 3'd1, 64'h0, 64'h8001_0000_0000_0000, 2'b00), 1);
        issue(mk(0, 32'h2006, 3'd5, 64'h0, 64'h8001_0000_0000_0000, 2'b00), 1);
        t = mk(1, 32'h10, 3'd2, 64'h1234_5678, 64'h0, 2'b00);
        t.w_dly = 3;
        issue(t, 0);
        issue(mk(0, 32'h40, 3'd7, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 2'b10), 1);
        issue(mk(0, 32'h3, 3'd2, 64'h0, 64'h1111_2222_8765_4321, 2'b00), 1);
        issue(mk(1, 32'h7, 3'd3, 64'h0102_0304_0506_0708, 64'h0, 2'b11), 1);

        // Reset while waiting on a withheld write response
        t = mk(1, 32'h88, 3'd3, 64'h55, 64'h0, 2'b00);
        t.b_dly = 1000;
        slq.push_back(t);
        i_req_valid = 1; i_req_we = 1; i_req_addr = t.addr; i_req_width = t.width;
        i_req_wdata = t.wdata;
        @(negedge clk);
        @(posedge clk); #1;
        i_req_valid = 0;
        ok = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (o_bready) begin ok = 1; break; end
        end
        chk("reached_wr_resp", ok, 1);
        @(posedge clk); #1 i_rst = 1;
        @(posedge clk); #1 i_rst = 0;
        @(negedge clk);
        chk("midrst_valids", {o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready, o_rsp_valid}, 0);
        chk("midrst_req_ready", o_req_ready, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("midrst_no_rsp", o_rsp_valid, 0);
        end
        @(posedge clk); #1;

        for (int n = 0; n < 150; n++) begin
            t.we     = $urandom_range(0, 1);
            t.addr   = $urandom & 32'h0000_FFFF;
            t.width  = t.we ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            t.wdata  = {$urandom, $urandom};
            t.bus    = {$urandom, $urandom};
            r        = $urandom_range(0, 5);
            t.resp   = (r == 4) ? 2'b10 : (r == 5) ? 2'b11 : 2'b00;
            t.aw_dly = $urandom_range(0, 3);
            t.w_dly  = $urandom_range(0, 3);
            t.b_dly  = $urandom_range(0, 3);
            t.ar_dly = $urandom_range(0, 3);
            t.r_dly  = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) begin
                t.aw_dly = 0; t.w_dly = 0; t.b_dly = 0; t.ar_dly = 0; t.r_dly = 0;
                issue(t, 1);
            end else begin
                issue(t, 0);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", scq.size(), 0);
        chk("slave_drained", slq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/riscv_lsu_axil_ctrl.md
Name: riscv_lsu_axil_ctrl

Overview:
- Load/store sequencer between the RISC-V pipeline memory stage and the AXI-Lite master port.
- Accepts one load or store at a time and places store data/strobes on the correct byte lanes of the 64-bit bus.
- Runs the AXI-Lite AW/W/B or AR/R handshakes, then returns the extracted, sign- or zero-extended load data with an error flag.

Parameters:
- DATA_WIDTH, 64, bus and register data width (only 64 supported).
- ADDR_WIDTH, 32, byte address width.
- STRB_WIDTH, DATA_WIDTH/8, write strobe width.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; synchronous, active-high.
- i_req_valid  in  1  pipeline request valid.
- o_req_ready  out  1  controller can accept a request.
- i_req_we  in  1  1=store, 0=load.
- i_req_addr  in  ADDR_WIDTH  byte address.
- i_req_width  in  3  funct3: [1:0] 0=byte/1=hword/2=word/3=dword; [2]=1 unsigned load.
- i_req_wdata  in  DATA_WIDTH  store data, right-justified.
- o_rsp_valid  out  1  one-cycle completion pulse, no backpressure.
- o_rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores.
- o_rsp_err  out  1  bus error or misalignment trap.
- o_awvalid/i_awready, o_awaddr[ADDR_WIDTH]  AXI-Lite write address.
- o_wvalid/i_wready, o_wdata[DATA_WIDTH], o_wstrb[STRB_WIDTH]  AXI-Lite write data.
- i_bvalid/o_bready, i_bresp[2]  AXI-Lite write response.
- o_arvalid/i_arready, o_araddr[ADDR_WIDTH]  AXI-Lite read address.
- i_rvalid/o_rready, i_rdata[DATA_WIDTH], i_rresp[2]  AXI-Lite read data.

Behaviour:
- Reset: state IDLE. All valid/ready outputs 0, o_rsp_rdata 0, o_rsp_err 0, addr/data/strb outputs 0.
- Reset mid-transaction: all valid/ready outputs deassert in the next cycle and the transaction is abandoned with no response. The interconnect is reset together with this block.
- States: IDLE, WR (AW+W), WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE: o_req_ready=1. On valid&ready, latch we, addr, width and wdata.
  - Store: go to WR.
  - Load: go to RD_ADDR.
  - Trapped misaligned access: go to DONE with err=1.
- Bus address: {addr[ADDR_WIDTH-1:3], 3'b000}.
- Lane select for stores, with o_wdata replicated into the selected lane(s):
  - byte: addr[2:0], strb = 1<<addr[2:0].
  - hword: addr[2:1], strb = 2'b11<<(2*addr[2:1]).
  - word: addr[2], strb = 4'hF<<(4*addr[2]).
  - dword: strb = 8'hFF.
- WR:
  - o_awvalid and o_wvalid both rise in the first WR cycle.
  - Each drops independently after its own handshake. AW and W may complete in any order or in the same cycle.
  - When both are done, go to WR_RESP.
- WR_RESP: o_bready=1. On i_bvalid, latch err = (bresp != 2'b00) and go to DONE.
- RD_ADDR: o_arvalid=1 until i_arready, then go to RD_DATA.
- RD_DATA: o_rready=1. On i_rvalid:
  - Extract the selected lane of i_rdata; sign-extend unless width[2].
  - Latch rdata and err = (rresp != 2'b00). On error, rdata=0.
  - Go to DONE.
- DONE: o_rsp_valid=1 for exactly one cycle, then go to IDLE. o_rsp_rdata/o_rsp_err hold until the next response.
- o_req_ready is 0 in every state except IDLE.
- Min latency, zero-wait slave:
  - Store: accept at cycle 0, AW/W at cycle 1, B at cycle 2, o_rsp_valid at cycle 3.
  - Load: accept at cycle 0, AR at cycle 1, R at cycle 2, o_rsp_valid at cycle 3.
- Dword loads: i_width[2] is ignored.

Optional Feature:
- RISCV_LSU_MISALIGN_TRAP_EN defined:
  - Misaligned accesses issue no bus transaction: hword with addr[0]≠0, word with addr[1:0]≠0, dword with addr[2:0]≠0.
  - Controller goes IDLE→DONE; o_rsp_valid asserts 2 cycles after accept with err=1, rdata=0.
- Undefined: address bits below natural alignment are ignored and the access proceeds at the truncated lane.

Test Plan:
- Store byte, addr 0x1005, wdata 0xAB, zero-wait slave -> awaddr 0x1000, wstrb 0x20, wdata[47:40]=0xAB, o_rsp_valid at cycle 3, err 0.
- Load hword signed, addr 0x2006, rdata 0x8001_0000_0000_0000 -> araddr 0x2000, o_rsp_rdata 0xFFFF_FFFF_FFFF_8001; same access unsigned -> 0x0000_0000_0000_8001.
- Store word, addr 0x10, wready 3 cycles after awready -> awvalid drops after its handshake, wvalid held until its handshake, single response, wstrb 0x0F.
- Load dword with rresp=2'b10 -> o_rsp_err 1, o_rsp_rdata 0, o_req_ready 1 in the cycle after o_rsp_valid.
- Word load at addr 0x3 with macro defined -> no arvalid, o_rsp_valid 2 cycles after accept, err 1; without macro -> araddr 0x0, lane [31:0] returned.
- i_rst asserted in WR_RESP with bvalid withheld -> next cycle all valid/ready 0, state IDLE, o_req_ready 1, no o_rsp_valid.
